// File: rtl/toggle_handshake_rx.sv
// Two-phase (toggle) handshake responder: each req_tgl level change becomes one queued
// event that is acknowledged on ack_tgl and drained to a local consumer over valid/ready.
module toggle_handshake_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       req_tgl,
    output logic                       ack_tgl,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
    output logic [CNT_W-1:0]           total_cnt
);

    localparam int unsigned PW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StEmpty,
        StPart,
        StFull
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_p_q, req_p_d;
    logic                   ack_q, ack_d;
    logic [PW-1:0]          pend_q, pend_d;
    logic [CNT_W-1:0]       total_q, total_d;
    state_e                 state;
    logic                   req_edge;
    logic                   drain;
    logic                   cap;

    assign req_s = sync_q[SYNC_STAGES-1];

    // Occupancy state is a decode of the pending count, not separate storage.
    always_comb begin
        if (pend_q == '0) begin
            state = StEmpty;
        end else if (pend_q == PW'(DEPTH)) begin
            state = StFull;
        end else begin
            state = StPart;
        end
    end

    assign drain    = (state != StEmpty) & evt_ready;
    assign req_edge = req_s ^ req_p_q;
    // When full, an edge is only taken if a slot frees up in the same cycle.
    assign cap      = en & req_edge & ((state != StFull) | drain);

    always_comb begin
        req_p_d = req_p_q;
        ack_d   = ack_q;
        pend_d  = pend_q;
        total_d = total_q;

        // While disabled, track the line so re-enabling does not see a stale edge.
        if (!en) begin
            req_p_d = req_s;
        end else if (cap) begin
            req_p_d = req_s;
            ack_d   = ~ack_q;
        end

        if (drain) begin
            total_d = total_q + CNT_W'(1);
        end

        unique case (state)
            StEmpty: begin
                if (cap) begin
                    pend_d = pend_q + PW'(1);
                end
            end
            StPart: begin
                if (cap && !drain) begin
                    pend_d = pend_q + PW'(1);
                end else if (drain && !cap) begin
                    pend_d = pend_q - PW'(1);
                end
            end
            StFull: begin
                if (drain && !cap) begin
                    pend_d = pend_q - PW'(1);
                end
            end
            default: begin
                pend_d = pend_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            req_p_q <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= '0;
            total_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req_tgl};
            req_p_q <= req_p_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            total_q <= total_d;
        end
    end

    assign ack_tgl   = ack_q;
    assign evt_valid = (state != StEmpty);
    assign full      = (state == StFull);
    assign pend_cnt  = pend_q;
    assign total_cnt = total_q;

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Two-phase (toggle) handshake responder. It samples a request toggle line driven by a T-flip-flop based initiator and turns each toggle into one queued event. It returns an acknowledge toggle per captured event and drains queued events to a local consumer over a valid/ready interface. It sits at the receiving end of the toggle-signalling path and replaces ad-hoc edge detectors on `t`/`q`-style lines.

## Interface
- `SYNC_STAGES`, default 2: flops in the `req_tgl` synchroniser; legal range 2..4.
- `DEPTH`, default 4: maximum pending events; legal range 1..15.
- `CNT_W`, default 16: width of `total_cnt`.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset. Assertion clears all state immediately; release is synchronous to `clk`.
- `en`  in  1: capture enable.
- `req_tgl`  in  1: request toggle from the initiator. Each level change is one request.
- `ack_tgl`  out  1: acknowledge toggle. Changes level once per captured request.
- `evt_valid`  out  1: at least one event is pending.
- `evt_ready`  in  1: consumer accepts one event when high together with `evt_valid`.
- `full`  out  1: pending count equals `DEPTH`.
- `pend_cnt`  out  clog2(DEPTH+1): number of pending events.
- `total_cnt`  out  CNT_W: number of events drained since reset; wraps modulo 2^CNT_W.

## Operation
- Synchroniser: `req_tgl` passes through a `SYNC_STAGES` flop chain; its last stage is `req_s`. Register `req_p` holds the last accepted level of `req_s`.
- Edge: `edge = (req_s != req_p)`.
- Capture condition: `cap = en & edge & (~full | drain)`, where `drain = evt_valid & evt_ready`. When `cap` is true on a clock edge:
  - `req_p` loads `req_s`.
  - `ack_tgl` inverts.
  - The pending count is incremented.
- Back-pressure: when `edge` holds, `en` is 1 and the block is full with no drain, `req_p` is held. The edge stays pending and `ack_tgl` does not change. A compliant initiator waits for the ack, so no request is lost.
- Disabled capture: with `en=0`, `req_p` follows `req_s` every cycle. Toggles seen while disabled are discarded and not acknowledged, and setting `en` back to 1 produces no spurious event. The initiator is responsible for recovering its own state after discarded toggles.
- Drain: each `drain` decrements the pending count and increments `total_cnt`.
- Capture and drain in the same cycle: `pend_cnt` is unchanged, `ack_tgl` still inverts and `total_cnt` increments.
- Derived outputs:
  - `evt_valid = (pend_cnt != 0)`.
  - `full = (pend_cnt == DEPTH)`.
  - `pend_cnt` never exceeds `DEPTH` and never goes below 0.
- State machine, derived from `pend_cnt`:
  - EMPTY (0): only capture is possible, giving PART (or FULL if `DEPTH=1`).
  - PART (1..DEPTH-1): capture moves up, drain moves down, both together stay.
  - FULL (DEPTH): capture only with a simultaneous drain; drain alone gives PART.
- Reset values:
  - All synchroniser flops, `req_p` and `ack_tgl` are 0.
  - `pend_cnt` and `total_cnt` are 0.
  - `evt_valid` and `full` are 0.
- The initiator must also reset `req_tgl` to 0; otherwise one event is captured after reset release.

## Timing
- Toggle-to-ack latency: `req_tgl` changes before rising edge 0, so `req_s` changes at edge `SYNC_STAGES-1`. `ack_tgl` inverts, and `pend_cnt`/`evt_valid` update, at edge `SYNC_STAGES`. With the default this is 2 edges, i.e. 3 cycles worst case from an asynchronous change.
- Drain: handshake at edge N, so `pend_cnt`, `evt_valid`, `full` and `total_cnt` update at edge N, visible in the next cycle. Back-to-back drains run one per cycle.
- Throughput: one capture per cycle maximum. Sustained compliant rate is limited by the initiator's round-trip of roughly `2*SYNC_STAGES+2` cycles.
- Reset asserted mid-operation clears all state within the same cycle, with no clock needed. Pending events are lost and `ack_tgl` returns to 0.
- All outputs are registered or decoded from registers only; no combinational path runs from `evt_ready` or `req_tgl` to any output.

## Test plan
- Reset: hold `rst=0` with `req_tgl=0` -> `ack_tgl=0`, `evt_valid=0`, `full=0`, `pend_cnt=0`, `total_cnt=0`; on release, no output change.
- Single request: `en=1`, `evt_ready=0`, `req_tgl` 0->1 before edge 0 -> `ack_tgl`=1, `pend_cnt`=1, `evt_valid`=1 after edge 2. Then `evt_ready=1` for one cycle -> `pend_cnt`=0, `total_cnt`=1.
- Fill and stall (`DEPTH=4`): `evt_ready=0` with 5 compliant toggles, each issued after its ack -> 4 acks, `pend_cnt`=4, `full`=1, 5th ack withheld. Then `evt_ready=1` for one cycle -> 5th captured in the same cycle, `pend_cnt` stays 4, `ack_tgl` toggles, `total_cnt`=1.
- Disabled: `en=0`, toggle `req_tgl` twice -> no ack change, `pend_cnt`=0. Then `en=1` for 10 cycles -> `evt_valid` stays 0.
- Reset mid-operation: `pend_cnt`=3, `ack_tgl`=1, pulse `rst` low between clock edges -> all outputs 0 immediately, including `ack_tgl`. With `req_tgl` driven to 0, no event occurs after release.
- Counter wrap (`CNT_W=4`): drain 17 events -> `total_cnt`=1, `pend_cnt`=0.
